key_debouncer: RTL and testbench
================================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 The module SHALL have parameter N_KEYS, default 4, giving the number of independent button channels.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 20, giving the per-channel counter width.
REQ-003 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), giving the stability window; legal range is 1 to 2^CNT_WIDTH-1.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_n  input  N_KEYS  raw push-buttons; asynchronous to clk, active-low, may bounce.
REQ-007 key_level  output  N_KEYS  debounced, active-high, registered press level per channel; drives the downstream rising-edge pulse generator.
REQ-008 any_pressed  output  1  OR of all key_level bits; combinational from registers only.

Function
REQ-009 Each channel SHALL pass its key_n bit through a two-flop synchronizer.
REQ-010 Each channel SHALL use the inverted second synchronizer stage as its synchronized press value, sp.
REQ-011 Channels SHALL be fully independent: separate synchronizer, counter and level register, with no shared arbitration.
REQ-012 Mismatch accumulation: on each rising edge where sp != key_level and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 Commit: on the rising edge where sp != key_level and the counter equals DEBOUNCE_CYCLES-1, key_level SHALL toggle and the counter SHALL clear to 0 on that same edge.
REQ-014 Agreement: on any rising edge where sp == key_level, the counter SHALL clear to 0, so any bounce restarts the window.
REQ-015 Latency: if key_n changes and is first sampled at edge k, then, if held stable, key_level SHALL change exactly at edge k+1+DEBOUNCE_CYCLES, and not earlier.
REQ-016 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive edges at sp SHALL never change key_level.
REQ-017 Press and release SHALL be debounced symmetrically, using the same window.
REQ-018 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 With DEBOUNCE_CYCLES=1, key_level SHALL follow sp with one cycle of delay.
REQ-020 Simultaneous changes on several channels SHALL each commit on their own schedule, with no interaction between channels.
REQ-021 key_level SHALL be glitch-free: it is a flop output with no combinational path from key_n.

Reset
REQ-022 While reset is high, independent of clk: synchronizer flops SHALL be 1 (released), counters SHALL be 0, key_level SHALL be 0, and any_pressed SHALL be 0.
REQ-023 Reset asserted mid-count SHALL discard the partial count.
REQ-024 After reset deasserts with a key already held, that channel SHALL be treated as a new press and SHALL commit per REQ-015.
REQ-025 No output SHALL toggle on the first clk edge after reset release.

Verification (bench uses DEBOUNCE_CYCLES=4, N_KEYS=4)
REQ-026 Clean press: key_n[0] 1->0, first sampled at edge 10 -> key_level[0]=1 and any_pressed=1 from edge 15; other bits stay 0.
REQ-027 Bounce rejection: key_n[1] low for 3 cycles, high 1 cycle, then low steadily from edge 20 -> no change before edge 25; key_level[1]=1 at edge 25.
REQ-028 Release: with key_level[2]=1, key_n[2] returns to 1 first sampled at edge 40 -> key_level[2]=0 at edge 45; a 2-cycle release glitch causes no change.
REQ-029 Simultaneous: key_n[3:0]=4'b0000 first sampled at the same edge -> all four key_level bits rise on the same edge, 5 edges later.
REQ-030 Reset mid-count: reset pulsed 2 cycles into a press window -> key_level stays 0 and the count restarts; with the key still held, key_level=1 five edges after the first post-reset sampling edge.
REQ-031 Reset while pressed: key_level=4'b0101 and reset asserted between edges -> key_level=0 and any_pressed=0 immediately, with no clk edge required.

Source files
------------

// File: rtl/key_debouncer.sv
// Multi-channel push-button debouncer: each channel has a 2-flop synchronizer,
// a stability counter and a registered active-high level. Channels share nothing.
module key_debouncer #(
  parameter int N_KEYS          = 4,
  parameter int CNT_WIDTH       = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic              any_pressed
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [N_KEYS-1:0]    sync1_q, sync2_q;
  logic [N_KEYS-1:0]    sp;
  logic [N_KEYS-1:0]    level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q [N_KEYS];
  logic [CNT_WIDTH-1:0] cnt_d [N_KEYS];

  // Synchronizer resets to "released" so a key held through reset is seen as a new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  assign sp = ~sync2_q;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sp[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_level   = level_q;
  assign any_pressed = |level_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed vector table, reset corner cases and
// randomized key activity checked every edge against a sample-window model.
module tb_key_debouncer;

  localparam int N = 4;
  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level;
  logic         any_pressed;

  key_debouncer #(.N_KEYS(N), .CNT_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .key_level(key_level),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // key_n as sampled on each edge since the last reset release; level
  // flips when the D samples that reached the synchronizer output before
  // this edge all disagree with the current level.
  logic [N-1:0] hist[$];
  logic [N-1:0] lvl_m = '0;

  typedef struct {
    logic [N-1:0] kn;
    int           hold;
    logic [N-1:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, required %b", name, act, exp);
  endtask

  function automatic logic [N-1:0] samp(input int idx);
    if (idx < 0) return '1;
    return hist[idx];
  endfunction

  task automatic step(input string tag);
    int e;
    logic ok;
    logic [N-1:0] s;
    @(posedge clk);
    if (!reset) begin
      hist.push_back(key_n);
      e = hist.size() - 1;
      for (int ch = 0; ch < N; ch++) begin
        ok = 1'b1;
        for (int j = e - 1 - D; j <= e - 2; j++) begin
          s = samp(j);
          if (s[ch] != lvl_m[ch]) ok = 1'b0;
        end
        if (ok) lvl_m[ch] = ~lvl_m[ch];
      end
    end else begin
      lvl_m = '0;
    end
    #1;
    check($sformatf("%s level", tag), key_level, lvl_m);
    check($sformatf("%s any", tag), {{(N-1){1'b0}}, any_pressed}, {{(N-1){1'b0}}, |lvl_m});
  endtask

  task automatic assert_reset();
    #2 reset = 1'b1;
    hist.delete();
    lvl_m = '0;
  endtask

  initial begin
    // edge indices below count from the first edge after reset release
    tbl.push_back('{4'hF, 10, 4'b0000});
    tbl.push_back('{4'hE,  5, 4'b0000});  // key0 sampled at 10, nothing yet at 14
    tbl.push_back('{4'hE,  1, 4'b0001});  // commit at 15
    tbl.push_back('{4'hC,  3, 4'b0001});  // key1 bounce: low 3
    tbl.push_back('{4'hE,  1, 4'b0001});  // high 1
    tbl.push_back('{4'hC,  5, 4'b0001});  // low steadily from 20
    tbl.push_back('{4'hC,  1, 4'b0011});  // commit at 25
    tbl.push_back('{4'h8,  5, 4'b0011});  // press key2
    tbl.push_back('{4'h8,  1, 4'b0111});
    tbl.push_back('{4'h8,  8, 4'b0111});
    tbl.push_back('{4'hC,  5, 4'b0111});  // release key2 sampled at 40
    tbl.push_back('{4'hC,  1, 4'b0011});  // commit at 45
    tbl.push_back('{4'h8,  5, 4'b0011});
    tbl.push_back('{4'h8,  1, 4'b0111});
    tbl.push_back('{4'hC,  2, 4'b0111});  // 2-cycle release glitch
    tbl.push_back('{4'h8,  8, 4'b0111});
    tbl.push_back('{4'hF,  5, 4'b0111});
    tbl.push_back('{4'hF,  1, 4'b0000});
    tbl.push_back('{4'h0,  5, 4'b0000});  // all four pressed together
    tbl.push_back('{4'h0,  1, 4'b1111});
    tbl.push_back('{4'hF,  5, 4'b1111});
    tbl.push_back('{4'hF,  1, 4'b0000});

    reset = 1'b1;
    key_n = '1;
    #12;
    check("reset level", key_level, '0);
    check("reset any", {{(N-1){1'b0}}, any_pressed}, '0);
    reset = 1'b0;

    foreach (tbl[r]) begin
      key_n = tbl[r].kn;
      repeat (tbl[r].hold) step($sformatf("tbl%0d", r));
      check($sformatf("tbl%0d end level", r), key_level, tbl[r].exp);
      check($sformatf("tbl%0d end any", r), {{(N-1){1'b0}}, any_pressed},
            {{(N-1){1'b0}}, |tbl[r].exp});
    end

    // reset two cycles into a press window, key still held afterwards
    key_n = 4'hE;
    repeat (2) step("midcnt pre");
    assert_reset();
    #1 check("midcnt in reset", key_level, 4'b0000);
    repeat (2) step("midcnt held");
    #2 reset = 1'b0;
    repeat (5) step("midcnt post");
    check("midcnt edge4", key_level, 4'b0000);
    step("midcnt post");
    check("midcnt edge5", key_level, 4'b0001);

    // reset while pressed clears outputs without a clock edge
    key_n = 4'hA;
    repeat (6) step("pressed");
    check("pressed 0101", key_level, 4'b0101);
    assert_reset();
    #2;
    check("async rst level", key_level, 4'b0000);
    check("async rst any", {{(N-1){1'b0}}, any_pressed}, '0);
    #1 reset = 1'b0;

    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) key_n[b] = ~key_n[b];
      step("rand");
      if (i == 300) begin
        assert_reset();
        #1 reset = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
